// File: rtl/lsu_master_pkg.sv
// Shared definitions for the Buceros load/store initiator: width codes,
// FSM encoding and the byte-lane mask helper.
package lsu_master_pkg;

    localparam int WORD_W = 32;
    localparam logic [WORD_W-1:0] ZERO_WORD = 32'h0000_0000;

    localparam logic [2:0] LSU_LB  = 3'b000;
    localparam logic [2:0] LSU_LH  = 3'b001;
    localparam logic [2:0] LSU_LW  = 3'b010;
    localparam logic [2:0] LSU_LBU = 3'b100;
    localparam logic [2:0] LSU_LHU = 3'b101;
    localparam logic [2:0] LSU_SB  = 3'b000;
    localparam logic [2:0] LSU_SH  = 3'b001;
    localparam logic [2:0] LSU_SW  = 3'b010;

    typedef enum logic [1:0] {
        LSU_IDLE = 2'd0,
        LSU_ACC0 = 2'd1,
        LSU_ACC1 = 2'd2,
        LSU_RESP = 2'd3
    } lsu_state_e;

    // Byte-lane mask for an access size taken from the low funct3 bits.
    function automatic logic [3:0] lsu_mask(input logic [1:0] size);
        logic [3:0] m;
        case (size)
            2'b00:   m = 4'h1;
            2'b01:   m = 4'h3;
            default: m = 4'hF;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane steering for stores and alignment/extension for loads,
// including detection of word-crossing accesses and illegal width codes.
module lsu_align
    import lsu_master_pkg::*;
(
    input  logic        we,
    input  logic [2:0]  funct3,
    input  logic [1:0]  off,
    input  logic [31:0] wdata,
    input  logic [63:0] rdata_pair,
    output logic [3:0]  sel0,
    output logic [3:0]  sel1,
    output logic [31:0] data0,
    output logic [31:0] data1,
    output logic        split,
    output logic        illegal,
    output logic [31:0] load_data
);

    logic [7:0]  mask_sh_s;
    logic [31:0] shifted_s;
    logic [4:0]  bit_off_s;

    // Lane positioning of the store data across the two possible words.
    always_comb begin
        bit_off_s = {off, 3'b000};
        mask_sh_s = {4'b0000, lsu_mask(funct3[1:0])} << off;
        sel0      = mask_sh_s[3:0];
        sel1      = mask_sh_s[7:4];
        split     = |mask_sh_s[7:4];
        data0     = wdata << bit_off_s;
        data1     = wdata >> (6'd32 - {1'b0, bit_off_s});
    end

    // Stores accept only SB/SH/SW; loads reject the three unused codes.
    always_comb begin
        if (we) begin
            illegal = (funct3 != LSU_SB) && (funct3 != LSU_SH) && (funct3 != LSU_SW);
        end else begin
            illegal = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
        end
    end

    // Extract the addressed bytes from {hi,lo} and extend to a full word.
    always_comb begin
        shifted_s = rdata_pair[bit_off_s +: 32];
        case (funct3)
            LSU_LB:  load_data = {{24{shifted_s[7]}}, shifted_s[7:0]};
            LSU_LH:  load_data = {{16{shifted_s[15]}}, shifted_s[15:0]};
            LSU_LW:  load_data = shifted_s;
            LSU_LBU: load_data = {24'h000000, shifted_s[7:0]};
            LSU_LHU: load_data = {16'h0000, shifted_s[15:0]};
            default: load_data = ZERO_WORD;
        endcase
    end

endmodule

// File: rtl/lsu_master.sv
// Load/store bus initiator: one request at a time, split into at most two
// word accesses on a combinational-read RAM port, with registered outputs.
module lsu_master
    import lsu_master_pkg::*;
#(
    parameter int ADDR_W = 32
)
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic              req_we_i,
    input  logic [2:0]        req_funct3_i,
    input  logic [ADDR_W-1:0] req_addr_i,
    input  logic [31:0]       req_wdata_i,
    output logic              resp_valid_o,
    output logic [31:0]       resp_rdata_o,
    output logic              resp_err_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic              mem_w_en_o,
    output logic [31:0]       mem_w_data_o,
    output logic [3:0]        mem_w_sel_o,
    input  logic [31:0]       mem_r_data_i
);

    lsu_state_e        state_r, state_next_s;
    logic              we_r;
    logic [2:0]        funct3_r;
    logic [ADDR_W-1:0] addr_r;
    logic [31:0]       wdata_r;
    logic [31:0]       lo_r;

    logic              src_we_s;
    logic [2:0]        src_funct3_s;
    logic [ADDR_W-1:0] src_addr_s;
    logic [31:0]       src_wdata_s;
    logic [63:0]       pair_s;
    logic [ADDR_W-1:0] word_addr_s;
    logic [ADDR_W-1:0] next_word_s;

    logic [3:0]        sel0_s, sel1_s;
    logic [31:0]       data0_s, data1_s, load_data_s;
    logic              split_s, illegal_s;

    logic              ready_d, resp_valid_d, resp_err_d, w_en_d;
    logic [31:0]       resp_rdata_d, w_data_d;
    logic [3:0]        w_sel_d;
    logic [ADDR_W-1:0] addr_d;

    logic              ready_r, resp_valid_r, resp_err_r, w_en_r;
    logic [31:0]       resp_rdata_r, w_data_r;
    logic [3:0]        w_sel_r;
    logic [ADDR_W-1:0] mem_addr_r;

    // Outputs are registered, so decode uses the live request while idle
    // and the latched request once an access is underway.
    always_comb begin
        if (state_r == LSU_IDLE) begin
            src_we_s     = req_we_i;
            src_funct3_s = req_funct3_i;
            src_addr_s   = req_addr_i;
            src_wdata_s  = req_wdata_i;
        end else begin
            src_we_s     = we_r;
            src_funct3_s = funct3_r;
            src_addr_s   = addr_r;
            src_wdata_s  = wdata_r;
        end
        if (state_r == LSU_ACC1) begin
            pair_s = {mem_r_data_i, lo_r};
        end else begin
            pair_s = {ZERO_WORD, mem_r_data_i};
        end
        word_addr_s = {src_addr_s[ADDR_W-1:2], 2'b00};
        next_word_s = {src_addr_s[ADDR_W-1:2] + {{(ADDR_W-3){1'b0}}, 1'b1}, 2'b00};
    end

    lsu_align u_align (
        .we         (src_we_s),
        .funct3     (src_funct3_s),
        .off        (src_addr_s[1:0]),
        .wdata      (src_wdata_s),
        .rdata_pair (pair_s),
        .sel0       (sel0_s),
        .sel1       (sel1_s),
        .data0      (data0_s),
        .data1      (data1_s),
        .split      (split_s),
        .illegal    (illegal_s),
        .load_data  (load_data_s)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= LSU_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            LSU_IDLE: begin
                if (req_valid_i) begin
                    state_next_s = illegal_s ? LSU_RESP : LSU_ACC0;
                end else begin
                    state_next_s = LSU_IDLE;
                end
            end
            LSU_ACC0: state_next_s = split_s ? LSU_ACC1 : LSU_RESP;
            LSU_ACC1: state_next_s = LSU_RESP;
            LSU_RESP: state_next_s = LSU_IDLE;
            default:  state_next_s = LSU_IDLE;
        endcase
    end

    // FSM output logic: values the output registers take in the next state.
    always_comb begin
        ready_d      = (state_next_s == LSU_IDLE);
        resp_valid_d = (state_next_s == LSU_RESP);
        resp_err_d   = 1'b0;
        resp_rdata_d = ZERO_WORD;
        addr_d       = '0;
        w_en_d       = 1'b0;
        w_sel_d      = 4'h0;
        w_data_d     = ZERO_WORD;
        case (state_next_s)
            LSU_ACC0: begin
                addr_d = word_addr_s;
                if (src_we_s) begin
                    w_en_d   = 1'b1;
                    w_sel_d  = sel0_s;
                    w_data_d = data0_s;
                end else begin
                    w_en_d   = 1'b0;
                end
            end
            LSU_ACC1: begin
                addr_d = next_word_s;
                if (src_we_s) begin
                    w_en_d   = 1'b1;
                    w_sel_d  = sel1_s;
                    w_data_d = data1_s;
                end else begin
                    w_en_d   = 1'b0;
                end
            end
            LSU_RESP: begin
                if (state_r == LSU_IDLE) begin
                    resp_err_d = 1'b1;
                end else if (!src_we_s) begin
                    resp_rdata_d = load_data_s;
                end else begin
                    resp_rdata_d = ZERO_WORD;
                end
            end
            default: begin
                addr_d = '0;
            end
        endcase
    end

    // Request latch on handshake and low-word capture for loads.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_r     <= 1'b0;
            funct3_r <= 3'b000;
            addr_r   <= '0;
            wdata_r  <= ZERO_WORD;
            lo_r     <= ZERO_WORD;
        end else begin
            if (state_r == LSU_IDLE && req_valid_i) begin
                we_r     <= req_we_i;
                funct3_r <= req_funct3_i;
                addr_r   <= req_addr_i;
                wdata_r  <= req_wdata_i;
            end
            if (state_r == LSU_ACC0 && !we_r) begin
                lo_r <= mem_r_data_i;
            end
        end
    end

    // Output registers; reset clears them asynchronously so w_en drops at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready_r      <= 1'b1;
            resp_valid_r <= 1'b0;
            resp_err_r   <= 1'b0;
            resp_rdata_r <= ZERO_WORD;
            mem_addr_r   <= '0;
            w_en_r       <= 1'b0;
            w_sel_r      <= 4'h0;
            w_data_r     <= ZERO_WORD;
        end else begin
            ready_r      <= ready_d;
            resp_valid_r <= resp_valid_d;
            resp_err_r   <= resp_err_d;
            resp_rdata_r <= resp_rdata_d;
            mem_addr_r   <= addr_d;
            w_en_r       <= w_en_d;
            w_sel_r      <= w_sel_d;
            w_data_r     <= w_data_d;
        end
    end

    assign req_ready_o  = ready_r;
    assign resp_valid_o = resp_valid_r;
    assign resp_err_o   = resp_err_r;
    assign resp_rdata_o = resp_rdata_r;
    assign mem_addr_o   = mem_addr_r;
    assign mem_w_en_o   = w_en_r;
    assign mem_w_sel_o  = w_sel_r;
    assign mem_w_data_o = w_data_r;

endmodule

// File: tb/tb_lsu_master.sv
// Directed self-checking bench for lsu_master with a small byte-lane RAM model.
module tb_lsu_master;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] mem_addr;
    logic        mem_w_en;
    logic [31:0] mem_w_data;
    logic [3:0]  mem_w_sel;
    logic [31:0] mem_r_data;

    logic [31:0] ram [256];
    int checks;
    int errors;

    lsu_master #(.ADDR_W(32)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid_i  (req_valid),
        .req_ready_o  (req_ready),
        .req_we_i     (req_we),
        .req_funct3_i (req_funct3),
        .req_addr_i   (req_addr),
        .req_wdata_i  (req_wdata),
        .resp_valid_o (resp_valid),
        .resp_rdata_o (resp_rdata),
        .resp_err_o   (resp_err),
        .mem_addr_o   (mem_addr),
        .mem_w_en_o   (mem_w_en),
        .mem_w_data_o (mem_w_data),
        .mem_w_sel_o  (mem_w_sel),
        .mem_r_data_i (mem_r_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign mem_r_data = ram[mem_addr[9:2]];

    always @(posedge clk) begin
        if (mem_w_en) begin
            for (int n = 0; n < 4; n++) begin
                if (mem_w_sel[n]) ram[mem_addr[9:2]][8*n +: 8] <= mem_w_data[8*n +: 8];
            end
        end
    end

    // Present one request; returns just after the handshake edge T.
    task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = d;
        @(posedge clk);
        #1;
        req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b000; req_addr = 32'h0; req_wdata = 32'h0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b000;
        req_addr = 32'h0; req_wdata = 32'h0;
        repeat (2) @(negedge clk);
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b exp 1", req_ready); end
        checks++; if (resp_valid !== 1'b0 || resp_err !== 1'b0 || resp_rdata !== 32'h0) begin errors++; $display("FAIL reset_resp got v=%b e=%b d=%h exp zeros", resp_valid, resp_err, resp_rdata); end
        checks++; if (mem_w_en !== 1'b0 || mem_addr !== 32'h0 || mem_w_sel !== 4'h0 || mem_w_data !== 32'h0) begin errors++; $display("FAIL reset_mem got en=%b a=%h s=%h d=%h exp zeros", mem_w_en, mem_addr, mem_w_sel, mem_w_data); end
        rst_n = 1'b1;
    endtask

    task automatic test_aligned_word();
        issue(1'b1, 3'b010, 32'h0000_0100, 32'hDEAD_BEEF);
        @(negedge clk);
        checks++; if (mem_addr !== 32'h100 || mem_w_sel !== 4'hF || mem_w_en !== 1'b1 || mem_w_data !== 32'hDEAD_BEEF) begin errors++; $display("FAIL sw_acc0 got a=%h s=%h en=%b d=%h exp 100/f/1/deadbeef", mem_addr, mem_w_sel, mem_w_en, mem_w_data); end
        @(negedge clk);
        checks++; if (resp_valid !== 1'b1 || resp_rdata !== 32'h0 || resp_err !== 1'b0 || mem_w_en !== 1'b0) begin errors++; $display("FAIL sw_resp got v=%b d=%h e=%b en=%b exp 1/0/0/0", resp_valid, resp_rdata, resp_err, mem_w_en); end
        issue(1'b0, 3'b010, 32'h0000_0100, 32'h0);
        @(negedge clk);
        checks++; if (mem_addr !== 32'h100 || mem_w_en !== 1'b0 || resp_valid !== 1'b0) begin errors++; $display("FAIL lw_acc0 got a=%h en=%b v=%b exp 100/0/0", mem_addr, mem_w_en, resp_valid); end
        @(negedge clk);
        checks++; if (resp_valid !== 1'b1 || resp_rdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL lw_resp got v=%b d=%h exp 1/deadbeef", resp_valid, resp_rdata); end
    endtask

    task automatic test_byte_lanes();
        issue(1'b1, 3'b000, 32'h0000_0103, 32'h0000_0080);
        @(negedge clk);
        checks++; if (mem_addr !== 32'h100 || mem_w_sel !== 4'h8 || mem_w_data !== 32'h8000_0000) begin errors++; $display("FAIL sb_acc0 got a=%h s=%h d=%h exp 100/8/80000000", mem_addr, mem_w_sel, mem_w_data); end
        @(negedge clk);
        issue(1'b0, 3'b000, 32'h0000_0103, 32'h0);
        repeat (2) @(negedge clk);
        checks++; if (resp_valid !== 1'b1 || resp_rdata !== 32'hFFFF_FF80) begin errors++; $display("FAIL lb_resp got v=%b d=%h exp 1/ffffff80", resp_valid, resp_rdata); end
        issue(1'b0, 3'b100, 32'h0000_0103, 32'h0);
        repeat (2) @(negedge clk);
        checks++; if (resp_valid !== 1'b1 || resp_rdata !== 32'h0000_0080) begin errors++; $display("FAIL lbu_resp got v=%b d=%h exp 1/00000080", resp_valid, resp_rdata); end
        issue(1'b0, 3'b101, 32'h0000_0100, 32'h0);
        repeat (2) @(negedge clk);
        checks++; if (resp_rdata !== 32'h0000_BEEF) begin errors++; $display("FAIL lhu_resp got %h exp 0000beef", resp_rdata); end
    endtask

    task automatic test_split();
        issue(1'b1, 3'b010, 32'h0000_0202, 32'h1122_3344);
        @(negedge clk);
        checks++; if (mem_addr !== 32'h200 || mem_w_sel !== 4'hC || mem_w_data !== 32'h3344_0000 || mem_w_en !== 1'b1) begin errors++; $display("FAIL ssw_acc0 got a=%h s=%h d=%h en=%b exp 200/c/33440000/1", mem_addr, mem_w_sel, mem_w_data, mem_w_en); end
        @(negedge clk);
        checks++; if (mem_addr !== 32'h204 || mem_w_sel !== 4'h3 || mem_w_data !== 32'h0000_1122 || resp_valid !== 1'b0) begin errors++; $display("FAIL ssw_acc1 got a=%h s=%h d=%h v=%b exp 204/3/00001122/0", mem_addr, mem_w_sel, mem_w_data, resp_valid); end
        @(negedge clk);
        checks++; if (resp_valid !== 1'b1 || mem_w_en !== 1'b0) begin errors++; $display("FAIL ssw_resp got v=%b en=%b exp 1/0", resp_valid, mem_w_en); end
        issue(1'b0, 3'b010, 32'h0000_0202, 32'h0);
        @(negedge clk);
        @(negedge clk);
        checks++; if (mem_addr !== 32'h204 || resp_valid !== 1'b0) begin errors++; $display("FAIL slw_acc1 got a=%h v=%b exp 204/0", mem_addr, resp_valid); end
        @(negedge clk);
        checks++; if (resp_valid !== 1'b1 || resp_rdata !== 32'h1122_3344) begin errors++; $display("FAIL slw_resp got v=%b d=%h exp 1/11223344", resp_valid, resp_rdata); end
    endtask

    task automatic test_wrap();
        issue(1'b1, 3'b001, 32'hFFFF_FFFF, 32'h0000_9234);
        @(negedge clk);
        checks++; if (mem_addr !== 32'hFFFF_FFFC || mem_w_sel !== 4'h8 || mem_w_data !== 32'h3400_0000) begin errors++; $display("FAIL wsh_acc0 got a=%h s=%h d=%h exp fffffffc/8/34000000", mem_addr, mem_w_sel, mem_w_data); end
        @(negedge clk);
        checks++; if (mem_addr !== 32'h0 || mem_w_sel !== 4'h1 || mem_w_data !== 32'h0000_0092) begin errors++; $display("FAIL wsh_acc1 got a=%h s=%h d=%h exp 0/1/00000092", mem_addr, mem_w_sel, mem_w_data); end
        @(negedge clk);
        issue(1'b0, 3'b001, 32'hFFFF_FFFF, 32'h0);
        repeat (3) @(negedge clk);
        checks++; if (resp_valid !== 1'b1 || resp_rdata !== 32'hFFFF_9234) begin errors++; $display("FAIL wlh_resp got v=%b d=%h exp 1/ffff9234", resp_valid, resp_rdata); end
        issue(1'b0, 3'b101, 32'hFFFF_FFFF, 32'h0);
        repeat (3) @(negedge clk);
        checks++; if (resp_valid !== 1'b1 || resp_rdata !== 32'h0000_9234) begin errors++; $display("FAIL wlhu_resp got v=%b d=%h exp 1/00009234", resp_valid, resp_rdata); end
    endtask

    task automatic test_illegal();
        issue(1'b0, 3'b011, 32'h0000_0100, 32'h0);
        @(negedge clk);
        checks++; if (resp_valid !== 1'b1 || resp_err !== 1'b1 || resp_rdata !== 32'h0 || mem_w_en !== 1'b0) begin errors++; $display("FAIL ill_ld got v=%b e=%b d=%h en=%b exp 1/1/0/0", resp_valid, resp_err, resp_rdata, mem_w_en); end
        issue(1'b1, 3'b100, 32'h0000_0100, 32'hFFFF_FFFF);
        @(negedge clk);
        checks++; if (resp_valid !== 1'b1 || resp_err !== 1'b1 || resp_rdata !== 32'h0 || mem_w_en !== 1'b0) begin errors++; $display("FAIL ill_st got v=%b e=%b d=%h en=%b exp 1/1/0/0", resp_valid, resp_err, resp_rdata, mem_w_en); end
        @(negedge clk);
        checks++; if (resp_err !== 1'b0 || req_ready !== 1'b1) begin errors++; $display("FAIL ill_after got e=%b r=%b exp 0/1", resp_err, req_ready); end
        checks++; if (ram[64] !== 32'h80AD_BEEF) begin errors++; $display("FAIL ill_ram got %h exp 80adbeef", ram[64]); end
    endtask

    task automatic test_back_to_back();
        int lat;
        issue(1'b0, 3'b010, 32'h0000_0100, 32'h0);
        repeat (2) @(negedge clk);
        issue(1'b0, 3'b010, 32'h0000_0200, 32'h0);
        lat = 0;
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            if (lat == 0 && resp_valid === 1'b1) lat = i;
        end
        checks++; if (lat != 2) begin errors++; $display("FAIL b2b_latency got %0d exp 2", lat); end
        checks++; if (resp_rdata !== 32'h0) begin errors++; $display("FAIL b2b_idle_rdata got %h exp 0", resp_rdata); end
    endtask

    task automatic test_reset_mid();
        int pulses;
        issue(1'b1, 3'b010, 32'h0000_0302, 32'hAABB_CCDD);
        @(negedge clk);
        @(negedge clk);
        checks++; if (mem_w_en !== 1'b1 || mem_addr !== 32'h304) begin errors++; $display("FAIL rm_acc1 got en=%b a=%h exp 1/304", mem_w_en, mem_addr); end
        rst_n = 1'b0;
        #1;
        checks++; if (mem_w_en !== 1'b0 || mem_addr !== 32'h0 || mem_w_sel !== 4'h0 || mem_w_data !== 32'h0 || resp_valid !== 1'b0) begin errors++; $display("FAIL rm_async got en=%b a=%h s=%h d=%h v=%b exp zeros", mem_w_en, mem_addr, mem_w_sel, mem_w_data, resp_valid); end
        @(negedge clk);
        rst_n = 1'b1;
        pulses = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (resp_valid === 1'b1) pulses++;
        end
        checks++; if (pulses != 0) begin errors++; $display("FAIL rm_no_resp got %0d pulses exp 0", pulses); end
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rm_ready got %b exp 1", req_ready); end
        checks++; if (ram[192][31:16] !== 16'hCCDD) begin errors++; $display("FAIL rm_first_word got %h exp ccdd", ram[192][31:16]); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_aligned_word();
        test_byte_lanes();
        test_split();
        test_wrap();
        test_illegal();
        test_back_to_back();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
